fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage of the RV32i pipeline. It holds the program counter and drives the instruction-memory address. It produces PC_F, PC_Plus_4_F and Predict_Taken_F for the fetch-to-decode pipeline register. Next-PC prediction uses a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The execute stage trains the BTB and redirects fetch on a mispredict.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
BTB_ENTRIES, 16, number of BTB entries; must be a power of two, minimum 2.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous, active-high reset.
Stall_En  input  1  hold PC (hazard stall); same signal as the decode-register stall.
Redirect_En  input  1  mispredict or jump correction from execute.
Redirect_PC  input  32  correct next PC when Redirect_En=1.
Update_En  input  1  resolved conditional branch or JAL in execute; trains the BTB.
Update_PC  input  32  PC of the resolved branch.
Update_Target  input  32  resolved branch target.
Update_Taken  input  1  actual branch outcome.
PC_F  output  32  current fetch PC; drives the imem address.
PC_Plus_4_F  output  32  PC_F + 4, modulo 2^32.
Predict_Taken_F  output  1  BTB predicts taken for PC_F.

Behaviour:
- Index and tag:
  - IB = log2(BTB_ENTRIES).
  - Index = PC[IB+1:2].
  - Tag = PC[31:IB+2].
  - PC[1:0] is ignored.
- Entry fields: valid (1 bit), tag, target (32 bits), ctr (2 bits).
- Lookup is combinational on PC_F.
  - Hit = valid && tag match.
  - Predict_Taken_F = hit && ctr[1] && !RST.
- Prediction target: Pred_PC = Predict_Taken_F ? BTB target : PC_PLUS_4_F.
- PC register update priority on each clock edge:
  1. RST: PC <= RESET_PC.
  2. Redirect_En: PC <= Redirect_PC.
  3. Stall_En: PC is held.
  4. Otherwise: PC <= Pred_PC.
- Redirect overrides a concurrent stall. Execute has already flushed the younger instructions in that case.
- Reset:
  - PC_F = RESET_PC, PC_Plus_4_F = RESET_PC+4, Predict_Taken_F = 0.
  - Every valid bit cleared; every ctr set to 2'b01.
  - Target and tag contents are don't-care after reset.
  - Reset mid-operation discards any pending redirect or update in that cycle.
- BTB training on Update_En (when RST=0):
  - Hit at Update_PC, taken: ctr saturating increment (max 2'b11); target <= Update_Target.
  - Hit at Update_PC, not taken: ctr saturating decrement (min 2'b00); target unchanged.
  - Miss, taken: allocate the entry: valid=1, tag, target, ctr=2'b10 (weakly taken). Any aliasing entry is overwritten.
  - Miss, not taken: no change.
- Training is independent of Stall_En and Redirect_En; updates are never dropped.
- Same-cycle lookup and update to the same index: lookup sees pre-update state (read-before-write). The new state is visible the following cycle.
- Latency:
  - Prediction: zero cycles; combinational in the same cycle as PC_F.
  - Redirect: PC_F equals Redirect_PC one cycle after Redirect_En.
- PC arithmetic wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Misalignment: no checks on Redirect_PC. The value is passed through as-is.
- Storage: BTB in flops, not block RAM. Single read port, single write port.

Test Plan:
1. Reset → hold RST 2 cycles, then release → PC_F=0x0000_0000, Predict_Taken_F=0; next edges give PC_F 0x4, 0x8, 0xC.
2. Train, then predict:
   - Update_En with Update_PC=0x10, Update_Target=0x40, Update_Taken=1.
   - Later, PC_F=0x10 → Predict_Taken_F=1; next PC_F=0x40.
3. Counter decay:
   - After scenario 2, one update at 0x10 with Update_Taken=0 → ctr 01; PC_F=0x10 gives Predict_Taken_F=0, next PC_F=0x14.
   - Two taken updates → ctr 11.
   - Then one not-taken update → ctr 10, still predicts taken.
4. Alias rejection:
   - Entry allocated for 0x10.
   - PC_F=0x50 (same index 4, different tag) → Predict_Taken_F=0, next PC_F=0x54.
   - Taken update at 0x50 replaces the entry; 0x10 then misses.
5. Priority:
   - Stall_En=1 with Redirect_En=1, Redirect_PC=0x200 → next PC_F=0x200.
   - Stall_En=1 alone, 3 cycles → PC_F constant.
   - A concurrent Update_En during the stall is still written.
6. Wrap and reset mid-operation:
   - PC reaches 0xFFFF_FFFC → PC_Plus_4_F=0x0, next PC_F=0x0.
   - RST asserted with Redirect_En=1 and Update_En=1 → PC_F=RESET_PC, BTB empty (no allocation).

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the RV32i pipeline.
//
// This stage holds the program counter, which also drives the instruction
// memory address. A direct-mapped branch target buffer (BTB) predicts the
// next PC. Each BTB entry has a valid bit, a tag, a 32-bit target and a
// 2-bit saturating counter. The execute stage trains the BTB with resolved
// branches and corrects fetch with a redirect when a prediction was wrong.
//
// Ports:
//   CLK              clock; all state updates on the rising edge
//   RST              synchronous active-high reset
//   Stall_En         hold the PC (hazard stall)
//   Redirect_En      load Redirect_PC into the PC (wins over Stall_En)
//   Redirect_PC      corrected next PC from execute
//   Update_En        train the BTB with a resolved branch or JAL
//   Update_PC        PC of the resolved branch
//   Update_Target    resolved branch target
//   Update_Taken     actual branch outcome
//   PC_F             current fetch PC (imem address)
//   PC_Plus_4_F      PC_F + 4, wrapping modulo 2^32
//   Predict_Taken_F  BTB predicts taken for PC_F
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Stall_En,
  input  logic        Redirect_En,
  input  logic [31:0] Redirect_PC,
  input  logic        Update_En,
  input  logic [31:0] Update_PC,
  input  logic [31:0] Update_Target,
  input  logic        Update_Taken,
  output logic [31:0] PC_F,
  output logic [31:0] PC_Plus_4_F,
  output logic        Predict_Taken_F
);

  localparam int unsigned IB    = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - IB;

  logic [31:0]      pc_q, pc_d;

  logic             valid_q  [BTB_ENTRIES];
  logic             valid_d  [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_d    [BTB_ENTRIES];
  logic [31:0]      target_q [BTB_ENTRIES];
  logic [31:0]      target_d [BTB_ENTRIES];
  logic [1:0]       ctr_q    [BTB_ENTRIES];
  logic [1:0]       ctr_d    [BTB_ENTRIES];

  logic [IB-1:0]    look_idx;
  logic [TAG_W-1:0] look_tag;
  logic             look_hit;
  logic [31:0]      pc_plus_4;
  logic [31:0]      pred_pc;

  logic [IB-1:0]    upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  // The byte-offset bits of the update PC never take part in indexing.
  logic             unused_upd_bits;
  assign unused_upd_bits = ^Update_PC[1:0];

  // Lookup path: read-before-write, so a same-cycle update to this index
  // only becomes visible on the next cycle.
  assign look_idx  = pc_q[IB+1:2];
  assign look_tag  = pc_q[31:IB+2];
  assign look_hit  = valid_q[look_idx] && (tag_q[look_idx] == look_tag);
  assign pc_plus_4 = pc_q + 32'd4;

  assign PC_F            = pc_q;
  assign PC_Plus_4_F     = pc_plus_4;
  assign Predict_Taken_F = look_hit && ctr_q[look_idx][1] && !RST;
  assign pred_pc         = Predict_Taken_F ? target_q[look_idx] : pc_plus_4;

  // Next PC: a redirect from execute wins over a stall, because execute has
  // already flushed the younger instructions the stall was protecting.
  always_comb begin
    pc_d = pred_pc;
    if (Redirect_En) begin
      pc_d = Redirect_PC;
    end else if (Stall_En) begin
      pc_d = pc_q;
    end
  end

  assign upd_idx = Update_PC[IB+1:2];
  assign upd_tag = Update_PC[31:IB+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // BTB training. Training ignores stall and redirect so that no resolved
  // branch is ever lost. A taken miss allocates the slot and evicts any
  // aliasing entry. A not-taken miss leaves the table unchanged.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (Update_En) begin
      if (upd_hit) begin
        if (Update_Taken) begin
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          end
          target_d[upd_idx] = Update_Target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (Update_Taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = Update_Target;
        ctr_d[upd_idx]    = 2'b10;
      end
    end
  end

  // Reset discards any redirect or update that arrives in the same cycle.
  // Counters restart weakly not-taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q <= RESET_PC;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Tags and targets need no reset, because a cleared valid bit masks them.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      tag_q    <= tag_d;
      target_q <= target_d;
    end
  end

endmodule
